sc_player_position_register: RTL and testbench

- Consumer end of the player shift-command interface.
- Receives the 2-bit one-cycle shift command produced by the player state machine.
- Holds the frog's horizontal position as a one-hot row vector and shifts it left or right with edge saturation.
- Reports edge status, blocked-move pulses and a move counter to the display matrix and game-control logic.

---
 rtl/sc_player_position_register.sv | 98 +++++++++
 tb/tb_sc_player_position_register.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sc_player_position_register.sv
// Player position register: holds the frog column as a one-hot row vector,
// shifts it on single-cycle left/right commands with edge saturation, and
// reports edge flags, blocked/illegal pulses and a saturating move counter.
module sc_player_position_register #(
  parameter int unsigned          DATAWIDTH     = 8,
  parameter logic [DATAWIDTH-1:0] INIT_POSITION = DATAWIDTH'(8'b00010000),
  parameter int unsigned          COUNTWIDTH    = 8
) (
  input  logic                  SC_PLAYER_STATEMACHINE_CLOCK_50,
  input  logic                  SC_PLAYER_STATEMACHINE_RESET_InHigh,
  input  logic [1:0]            SC_PLAYER_POSITION_ShiftSelection_In,
  input  logic                  SC_PLAYER_POSITION_Load_InLow,
  output logic [DATAWIDTH-1:0]  SC_PLAYER_POSITION_Data_Out,
  output logic                  SC_PLAYER_POSITION_AtLeftEdge_Out,
  output logic                  SC_PLAYER_POSITION_AtRightEdge_Out,
  output logic                  SC_PLAYER_POSITION_Blocked_Out,
  output logic                  SC_PLAYER_POSITION_Illegal_Out,
  output logic [COUNTWIDTH-1:0] SC_PLAYER_POSITION_MoveCount_Out
);

  localparam logic [1:0] CMD_HOLD    = 2'b00;
  localparam logic [1:0] CMD_LEFT    = 2'b01;
  localparam logic [1:0] CMD_RIGHT   = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  localparam logic [COUNTWIDTH-1:0] COUNT_MAX = {COUNTWIDTH{1'b1}};

  logic [DATAWIDTH-1:0]  data_q,    data_d;
  logic [COUNTWIDTH-1:0] count_q,   count_d;
  logic                  blocked_q, blocked_d;
  logic                  illegal_q, illegal_d;
  logic [COUNTWIDTH-1:0] count_inc;

  // Saturating successor of the move counter.
  always_comb begin
    count_inc = (count_q == COUNT_MAX) ? count_q : count_q + COUNTWIDTH'(1);
  end

  // Next-state: load, corruption recovery, then shift command decode.
  always_comb begin
    data_d    = data_q;
    count_d   = count_q;
    blocked_d = 1'b0;
    illegal_d = 1'b0;
    if (!SC_PLAYER_POSITION_Load_InLow) begin
      data_d  = INIT_POSITION;
      count_d = '0;
    end else if (data_q == '0) begin
      data_d = INIT_POSITION;
    end else begin
      case (SC_PLAYER_POSITION_ShiftSelection_In)
        CMD_LEFT: begin
          if (!data_q[DATAWIDTH-1]) begin
            data_d  = data_q << 1;
            count_d = count_inc;
          end else begin
            blocked_d = 1'b1;
          end
        end
        CMD_RIGHT: begin
          if (!data_q[0]) begin
            data_d  = data_q >> 1;
            count_d = count_inc;
          end else begin
            blocked_d = 1'b1;
          end
        end
        CMD_ILLEGAL: illegal_d = 1'b1;
        CMD_HOLD:    data_d    = data_q;
        default:     data_d    = data_q;
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge SC_PLAYER_STATEMACHINE_CLOCK_50 or posedge SC_PLAYER_STATEMACHINE_RESET_InHigh) begin
    if (SC_PLAYER_STATEMACHINE_RESET_InHigh) begin
      data_q    <= INIT_POSITION;
      count_q   <= '0;
      blocked_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      count_q   <= count_d;
      blocked_q <= blocked_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs: registered state plus edge decodes of the position register.
  assign SC_PLAYER_POSITION_Data_Out        = data_q;
  assign SC_PLAYER_POSITION_AtLeftEdge_Out  = data_q[DATAWIDTH-1];
  assign SC_PLAYER_POSITION_AtRightEdge_Out = data_q[0];
  assign SC_PLAYER_POSITION_Blocked_Out     = blocked_q;
  assign SC_PLAYER_POSITION_Illegal_Out     = illegal_q;
  assign SC_PLAYER_POSITION_MoveCount_Out   = count_q;

endmodule

// File: tb/tb_sc_player_position_register.sv
// Scoreboard bench for sc_player_position_register: an 8-bit-counter and a
// 2-bit-counter instance receive the same stimulus; expected outputs come
// from a behavioural model pushed into a queue when each command is driven.
module tb_sc_player_position_register;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cmd = 2'b00;
  logic       ld_n = 1'b1;

  logic [7:0] d8_data, d2_data;
  logic       d8_left, d8_right, d8_blk, d8_ill;
  logic       d2_left, d2_right, d2_blk, d2_ill;
  logic [7:0] d8_cnt;
  logic [1:0] d2_cnt;

  sc_player_position_register #(.DATAWIDTH(8), .INIT_POSITION(8'b00010000), .COUNTWIDTH(8)) u_dut8 (
    .SC_PLAYER_STATEMACHINE_CLOCK_50      (clk),
    .SC_PLAYER_STATEMACHINE_RESET_InHigh  (rst),
    .SC_PLAYER_POSITION_ShiftSelection_In (cmd),
    .SC_PLAYER_POSITION_Load_InLow        (ld_n),
    .SC_PLAYER_POSITION_Data_Out          (d8_data),
    .SC_PLAYER_POSITION_AtLeftEdge_Out    (d8_left),
    .SC_PLAYER_POSITION_AtRightEdge_Out   (d8_right),
    .SC_PLAYER_POSITION_Blocked_Out       (d8_blk),
    .SC_PLAYER_POSITION_Illegal_Out       (d8_ill),
    .SC_PLAYER_POSITION_MoveCount_Out     (d8_cnt)
  );

  sc_player_position_register #(.DATAWIDTH(8), .INIT_POSITION(8'b00010000), .COUNTWIDTH(2)) u_dut2 (
    .SC_PLAYER_STATEMACHINE_CLOCK_50      (clk),
    .SC_PLAYER_STATEMACHINE_RESET_InHigh  (rst),
    .SC_PLAYER_POSITION_ShiftSelection_In (cmd),
    .SC_PLAYER_POSITION_Load_InLow        (ld_n),
    .SC_PLAYER_POSITION_Data_Out          (d2_data),
    .SC_PLAYER_POSITION_AtLeftEdge_Out    (d2_left),
    .SC_PLAYER_POSITION_AtRightEdge_Out   (d2_right),
    .SC_PLAYER_POSITION_Blocked_Out       (d2_blk),
    .SC_PLAYER_POSITION_Illegal_Out       (d2_ill),
    .SC_PLAYER_POSITION_MoveCount_Out     (d2_cnt)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       blk;
    logic       ill;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [7:0] m_data = 8'b00010000;
  logic [7:0] m_c8   = 8'd0;
  logic [1:0] m_c2   = 2'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 8'b00010000;
    m_c8   = 8'd0;
    m_c2   = 2'd0;
  endtask

  // Drive one command, predict its result, compare after the capturing edge.
  task automatic step(input logic [1:0] c, input logic l);
    exp_t e;
    logic moved;
    @(negedge clk);
    cmd   = c;
    ld_n  = l;
    e.blk = 1'b0;
    e.ill = 1'b0;
    moved = 1'b0;
    if (!l) begin
      m_data = 8'b00010000;
      m_c8   = 8'd0;
      m_c2   = 2'd0;
    end else if (c == 2'b01) begin
      if (m_data[7]) e.blk = 1'b1;
      else begin m_data = {m_data[6:0], 1'b0}; moved = 1'b1; end
    end else if (c == 2'b10) begin
      if (m_data[0]) e.blk = 1'b1;
      else begin m_data = {1'b0, m_data[7:1]}; moved = 1'b1; end
    end else if (c == 2'b11) begin
      e.ill = 1'b1;
    end
    if (moved) begin
      if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
      if (m_c2 != 2'd3)  m_c2 = m_c2 + 2'd1;
    end
    e.data = m_data;
    e.c8   = m_c8;
    e.c2   = m_c2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("data",    32'(d8_data),  32'(e.data));
      chk("left",    32'(d8_left),  32'(e.data[7]));
      chk("right",   32'(d8_right), 32'(e.data[0]));
      chk("blocked", 32'(d8_blk),   32'(e.blk));
      chk("illegal", 32'(d8_ill),   32'(e.ill));
      chk("count8",  32'(d8_cnt),   32'(e.c8));
      chk("data_w2", 32'(d2_data),  32'(e.data));
      chk("blk_w2",  32'(d2_blk),   32'(e.blk));
      chk("count2",  32'(d2_cnt),   32'(e.c2));
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_data"},  32'(d8_data), 32'h10);
    chk({tag, "_cnt"},   32'(d8_cnt),  32'd0);
    chk({tag, "_blk"},   32'(d8_blk),  32'd0);
    chk({tag, "_ill"},   32'(d8_ill),  32'd0);
    chk({tag, "_cnt2"},  32'(d2_cnt),  32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    // Three lefts from reset, reaching the left edge.
    step(2'b01, 1'b1);
    step(2'b01, 1'b1);
    step(2'b01, 1'b1);
    chk("at_left_edge", 32'(d8_left), 32'd1);
    // Left at the edge: blocked for exactly one cycle, count stays.
    step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    chk("cnt_after_blk", 32'(d8_cnt), 32'd3);

    // Load back to init, then six consecutive rights.
    step(2'b00, 1'b0);
    for (int i = 0; i < 6; i++) step(2'b10, 1'b1);
    chk("cnt_after_rights", 32'(d8_cnt), 32'd4);
    chk("at_right_edge", 32'(d8_right), 32'd1);

    // Load wins over a right command at the right edge.
    step(2'b10, 1'b0);

    // Illegal command pulse, then hold.
    step(2'b11, 1'b1);
    step(2'b00, 1'b1);

    // Five legal moves: narrow counter saturates at 3.
    for (int i = 0; i < 3; i++) step(2'b01, 1'b1);
    for (int i = 0; i < 2; i++) step(2'b10, 1'b1);
    chk("sat_cnt2", 32'(d2_cnt), 32'd3);
    chk("cnt8_five", 32'(d8_cnt), 32'd5);

    // Random command mix with occasional loads.
    for (int i = 0; i < 60; i++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 15) != 0));
    end

    // Asynchronous reset mid-run while a command is applied.
    step(2'b01, 1'b1);
    @(negedge clk);
    cmd = 2'b01;
    #3;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(posedge clk);
    #1;
    check_reset_state("rst_held");
    @(negedge clk);
    cmd = 2'b00;
    rst = 1'b0;
    model_reset();
    step(2'b10, 1'b1);
    step(2'b00, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
